// File: rtl/float_pkg.sv
// Shared IEEE-754 single-precision field constants, classification enum and field extractors.
package float_pkg;

  localparam int unsigned FP_EXP_W    = 8;
  localparam int unsigned FP_MANT_W   = 23;
  localparam int unsigned FP_EXP_BIAS = 127;

  typedef enum logic [1:0] {FP_ZERO, FP_NORM, FP_INF, FP_NAN} fp_class_e;

  function automatic logic fp_sign(input logic [31:0] w);
    return w[31];
  endfunction

  function automatic logic [FP_EXP_W-1:0] fp_exp(input logic [31:0] w);
    return w[30:23];
  endfunction

  function automatic logic [FP_MANT_W-1:0] fp_frac(input logic [31:0] w);
    return w[22:0];
  endfunction

endpackage

// File: rtl/float_unpack.sv
// Combinational single-precision unpack: sign, class, mantissa with hidden bit, and the
// right-shift amount that aligns the mantissa LSB to a fixed-point grid of FRAC_W bits.
module float_unpack
  import float_pkg::*;
#(
  parameter int unsigned FRAC_W = 0
) (
  input  logic [31:0]          data_i,
  output logic                 sign_o,
  output fp_class_e            class_o,
  output logic [FP_MANT_W:0]   mant_o,
  output logic signed [9:0]    rs_o
);

  localparam logic signed [9:0] RsBase = 10'(int'(FP_EXP_BIAS + FP_MANT_W) - int'(FRAC_W));

  logic [FP_EXP_W-1:0]  exp_v;
  logic [FP_MANT_W-1:0] frac_v;

  always_comb begin
    exp_v  = fp_exp(data_i);
    frac_v = fp_frac(data_i);
    sign_o = fp_sign(data_i);
    mant_o = {exp_v != '0, frac_v};
    rs_o   = RsBase - $signed({2'b00, exp_v});
    if (exp_v == '0) begin
      class_o = FP_ZERO;
    end else if (exp_v == '1) begin
      class_o = (frac_v == '0) ? FP_INF : FP_NAN;
    end else begin
      class_o = FP_NORM;
    end
  end

endmodule

// File: rtl/float_to_fixed.sv
// Three-stage streaming float32 to signed fixed-point converter with saturation and NaN flags.
// Define FLOAT_TO_FIXED_ROUND_EN for round-to-nearest (ties away); default truncates toward zero.
module float_to_fixed
  import float_pkg::*;
#(
  parameter int unsigned OUT_W  = 16,
  parameter int unsigned FRAC_W = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_sat,
  output logic             out_nan
);

  localparam int unsigned     MagW      = OUT_W + 1;
  localparam logic [MagW:0]   MagOne    = {{MagW{1'b0}}, 1'b1};
  localparam logic [MagW:0]   MagMaxNeg = MagOne << (OUT_W - 1);
  localparam logic [MagW:0]   MagMaxPos = MagMaxNeg - MagOne;
  localparam logic [OUT_W-1:0] MaxVal   = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] MinVal   = {1'b1, {(OUT_W-1){1'b0}}};

  logic adv;

  logic                 u_sign;
  fp_class_e            u_class;
  logic [FP_MANT_W:0]   u_mant;
  logic signed [9:0]    u_rs;

  logic                 s1_valid_q, s1_sign_q;
  fp_class_e            s1_class_q;
  logic [FP_MANT_W:0]   s1_mant_q;
  logic signed [9:0]    s1_rs_q;

  logic                 s2_valid_q, s2_sign_q, s2_ovf_q;
  fp_class_e            s2_class_q;
  logic [MagW-1:0]      s2_mag_q;

  logic [63:0]          mant_ext, shf_d;
  logic [9:0]           lsh;
  logic                 big_d, ovf_d;
  logic [MagW-1:0]      mag_d;

  logic [MagW:0]        mag_r;
  logic [OUT_W-1:0]     out_data_d, out_data_q;
  logic                 out_sat_d, out_sat_q, out_nan_d, out_nan_q, out_valid_q;

  // Every stage moves together; a stalled output freezes the whole pipe.
  assign adv       = !out_valid_q || out_ready;
  assign in_ready  = adv;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;
  assign out_nan   = out_nan_q;

  float_unpack #(
    .FRAC_W (FRAC_W)
  ) u_unpack (
    .data_i  (in_data),
    .sign_o  (u_sign),
    .class_o (u_class),
    .mant_o  (u_mant),
    .rs_o    (u_rs)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
    end else if (adv) begin
      s1_valid_q <= in_valid;
      s2_valid_q <= s1_valid_q;
    end
  end

  always_ff @(posedge clk) begin
    if (adv) begin
      s1_sign_q  <= u_sign;
      s1_class_q <= u_class;
      s1_mant_q  <= u_mant;
      s1_rs_q    <= u_rs;
      s2_sign_q  <= s1_sign_q;
      s2_class_q <= s1_class_q;
      s2_mag_q   <= mag_d;
      s2_ovf_q   <= ovf_d;
    end
  end

  // Any set bit above the MagW-bit field, from either shift direction, is an overflow.
  always_comb begin
    mant_ext = {40'd0, s1_mant_q};
    shf_d    = '0;
    big_d    = 1'b0;
    lsh      = 10'(-s1_rs_q);
    if (s1_rs_q >= 0) begin
      if (s1_rs_q < 25) begin
        shf_d = mant_ext >> s1_rs_q[4:0];
      end
    end else if (lsh > 10'(OUT_W)) begin
      big_d = |s1_mant_q;
    end else begin
      shf_d = mant_ext << lsh[5:0];
    end
    ovf_d = big_d || (|(shf_d >> MagW));
    mag_d = ovf_d ? '1 : shf_d[MagW-1:0];
  end

`ifdef FLOAT_TO_FIXED_ROUND_EN
  logic guard_d, s2_guard_q;

  always_comb begin
    guard_d = 1'b0;
    if (s1_rs_q >= 1 && s1_rs_q <= 25) begin
      guard_d = mant_ext[s1_rs_q[5:0] - 6'd1];
    end
  end

  always_ff @(posedge clk) begin
    if (adv) begin
      s2_guard_q <= guard_d;
    end
  end

  always_comb begin
    mag_r = {1'b0, s2_mag_q} + {{MagW{1'b0}}, s2_guard_q};
  end
`else
  always_comb begin
    mag_r = {1'b0, s2_mag_q};
  end
`endif

  always_comb begin
    out_data_d = '0;
    out_sat_d  = 1'b0;
    out_nan_d  = 1'b0;
    unique case (s2_class_q)
      FP_ZERO: ;
      FP_NAN:  out_nan_d = 1'b1;
      FP_INF: begin
        out_sat_d  = 1'b1;
        out_data_d = s2_sign_q ? MinVal : MaxVal;
      end
      FP_NORM: begin
        if (s2_sign_q) begin
          if (s2_ovf_q || mag_r > MagMaxNeg) begin
            out_sat_d  = 1'b1;
            out_data_d = MinVal;
          end else begin
            out_data_d = -mag_r[OUT_W-1:0];
          end
        end else if (s2_ovf_q || mag_r > MagMaxPos) begin
          out_sat_d  = 1'b1;
          out_data_d = MaxVal;
        end else begin
          out_data_d = mag_r[OUT_W-1:0];
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
      out_nan_q   <= 1'b0;
    end else if (adv) begin
      out_valid_q <= s2_valid_q;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
      out_nan_q   <= out_nan_d;
    end
  end

endmodule

// File: tb/tb_float_to_fixed.sv
// Directed bench: two converter instances (16.0 and 12.8) share stimulus; sel picks the checked one.
module tb_float_to_fixed;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [31:0] in_data;
  logic        out_ready;

  logic        in_ready_a, out_valid_a, out_sat_a, out_nan_a;
  logic [15:0] out_data_a;
  logic        in_ready_b, out_valid_b, out_sat_b, out_nan_b;
  logic [11:0] out_data_b;

  logic        sel;
  logic        in_ready, out_valid, out_sat, out_nan;
  logic [31:0] out_data;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  float_to_fixed #(.OUT_W(16), .FRAC_W(0)) u_dut_a (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready_a),
    .in_data   (in_data),
    .out_valid (out_valid_a),
    .out_ready (out_ready),
    .out_data  (out_data_a),
    .out_sat   (out_sat_a),
    .out_nan   (out_nan_a)
  );

  float_to_fixed #(.OUT_W(12), .FRAC_W(8)) u_dut_b (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready_b),
    .in_data   (in_data),
    .out_valid (out_valid_b),
    .out_ready (out_ready),
    .out_data  (out_data_b),
    .out_sat   (out_sat_b),
    .out_nan   (out_nan_b)
  );

  always_comb begin
    if (sel) begin
      in_ready  = in_ready_b;
      out_valid = out_valid_b;
      out_sat   = out_sat_b;
      out_nan   = out_nan_b;
      out_data  = {{20{out_data_b[11]}}, out_data_b};
    end else begin
      in_ready  = in_ready_a;
      out_valid = out_valid_a;
      out_sat   = out_sat_a;
      out_nan   = out_nan_a;
      out_data  = {{16{out_data_a[15]}}, out_data_a};
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One word into an idle pipe; result must land in the third cycle after acceptance.
  task automatic run_one(input string tag, input logic [31:0] word, input int exp_d,
                         input bit exp_sat, input bit exp_nan);
    int cnt;
    @(negedge clk);
    in_valid  = 1'b1;
    in_data   = word;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    cnt = 1;
    while (!out_valid && cnt < 10) begin
      @(negedge clk);
      cnt++;
    end
    check({tag, "_lat"}, 32'(cnt), 32'd3);
    check({tag, "_data"}, out_data, 32'(exp_d));
    check({tag, "_sat"}, 32'(out_sat), 32'(exp_sat));
    check({tag, "_nan"}, 32'(out_nan), 32'(exp_nan));
  endtask

  logic [31:0] bp_vec [8] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                              32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};
  bit          bp_pat [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent, rcv, stale;
    bit hold;
    logic [31:0] held;

    reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1; sel = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid_a", 32'(out_valid), 32'd0);
    check("rst_data_a", out_data, 32'd0);
    check("rst_flags_a", 32'({out_sat, out_nan}), 32'd0);
    sel = 1'b1;
    #1;
    check("rst_valid_b", 32'(out_valid), 32'd0);
    check("rst_data_b", out_data, 32'd0);
    sel = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    check("rst_ready", 32'(in_ready), 32'd1);

    run_one("one", 32'h3F800000, 1, 1'b0, 1'b0);
`ifdef FLOAT_TO_FIXED_ROUND_EN
    run_one("m3p75", 32'hC0700000, -4, 1'b0, 1'b0);
    run_one("half", 32'h3F000000, 1, 1'b0, 1'b0);
    run_one("rnd_sat", 32'h46FFFF00, 32767, 1'b1, 1'b0);
`else
    run_one("m3p75", 32'hC0700000, -3, 1'b0, 1'b0);
    run_one("half", 32'h3F000000, 0, 1'b0, 1'b0);
    run_one("rnd_sat", 32'h46FFFF00, 32767, 1'b0, 1'b0);
`endif
    run_one("p40000", 32'h471C4000, 32767, 1'b1, 1'b0);
    run_one("m32768", 32'hC7000000, -32768, 1'b0, 1'b0);
    run_one("ninf", 32'hFF800000, -32768, 1'b1, 1'b0);
    run_one("pinf", 32'h7F800000, 32767, 1'b1, 1'b0);
    run_one("big", 32'h501502F9, 32767, 1'b1, 1'b0);
    run_one("nmax", 32'hFF7FFFFF, -32768, 1'b1, 1'b0);
    run_one("nan", 32'h7FC00000, 0, 1'b0, 1'b1);
    run_one("negz", 32'h80000000, 0, 1'b0, 1'b0);
    run_one("denorm", 32'h00000001, 0, 1'b0, 1'b0);
    run_one("q25", 32'h3E800000, 0, 1'b0, 1'b0);

    sel = 1'b1;
    run_one("f_half", 32'h3F000000, 128, 1'b0, 1'b0);
    run_one("f_7p5", 32'h40F00000, 1920, 1'b0, 1'b0);
    run_one("f_8", 32'h41000000, 2047, 1'b1, 1'b0);
    run_one("f_m8", 32'hC1000000, -2048, 1'b0, 1'b0);
    sel = 1'b0;

    // Backpressure: 8 back-to-back words, out_ready cycling 1,0,0,1,1.
    sent = 0; rcv = 0; hold = 1'b0; held = '0;
    for (int cyc = 0; cyc < 80 && rcv < 8; cyc++) begin
      @(negedge clk);
      if (hold) begin
        check("bp_hold_valid", 32'(out_valid), 32'd1);
        check("bp_hold_data", out_data, held);
      end
      out_ready = bp_pat[cyc % 5];
      in_valid  = (sent < 8);
      in_data   = (sent < 8) ? bp_vec[sent] : 32'h0;
      #1;
      check("bp_ready", 32'(in_ready), 32'(!(out_valid && !out_ready)));
      if (out_valid && out_ready) begin
        check("bp_data", out_data, 32'(rcv + 1));
        rcv++;
      end
      if (in_valid && in_ready) sent++;
      hold = out_valid && !out_ready;
      held = out_data;
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    check("bp_count", 32'(rcv), 32'd8);
    stale = 0;
    repeat (5) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    check("bp_nodup", 32'(stale), 32'd0);

    // Reset with three words in flight.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = bp_vec[i + 4];
    end
    @(negedge clk);
    in_valid = 1'b0;
    reset    = 1'b1;
    @(negedge clk);
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    reset = 1'b0;
    #1;
    check("mid_rst_ready", 32'(in_ready), 32'd1);
    stale = 0;
    repeat (5) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    check("mid_rst_stale", 32'(stale), 32'd0);
    run_one("post_rst", 32'hC0400000, -3, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/float_to_fixed.md
Name: float_to_fixed

Overview:
- Pipelined IEEE-754 single-precision to signed fixed-point converter for the DSP datapath, e.g. for the float-domain filter outputs feeding integer DAC/mixer paths.
- Generalises the earlier fixed 16-bit integer converter:
  - parametrised output width and fraction bits;
  - explicit saturation and NaN flags;
  - streaming valid/ready handshake with one result per cycle;
  - replaces the reset-pulse-started, single-shot conversion.

Parameters:
- OUT_W, 16, total output width incl. sign; legal 2..32.
- FRAC_W, 0, fractional bits of output; legal 0..OUT_W-1.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- in_valid  in  1  input word valid
- in_ready  out  1  converter accepts input this cycle
- in_data  in  32  IEEE-754 single (sign 31, exp 30:23, mant 22:0)
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_data  out  OUT_W  signed two's-complement result, FRAC_W fraction bits
- out_sat  out  1  result was clamped (overflow or ±Inf); qualified by out_valid
- out_nan  out  1  input was NaN; qualified by out_valid

Behaviour:
- Reset, synchronous active-high:
  - all stage valids clear;
  - out_valid=0, out_data=0, out_sat=0, out_nan=0.
  - Reset mid-stream drops in-flight words; in_ready=1 the cycle after reset deasserts.
- Pipeline is 3 stages, latency 3 cycles from the accepting edge to out_valid.
- Global advance: adv = !out_valid | out_ready; in_ready = adv.
  - Transfer occurs on in_valid & in_ready.
  - When adv=0, all stages hold and out_data stays stable.
  - Bubbles propagate as invalid stages; there is no bubble collapsing.
- S1 decode:
  - split sign, exp e, mant m = {e!=0, frac};
  - classify zero/denormal (e==0), inf (e==255, frac==0), NaN (e==255, frac!=0), normal;
  - compute rs = 150 - FRAC_W - e as a signed 10-bit value.
- S2 shift:
  - rs>=0: mag = m >> rs; also keep guard bit (bit rs-1) and sticky (OR of lower bits) for the optional rounding.
  - rs>=25: mag=0.
  - rs<0: mag = m << -rs into an OUT_W+1-bit field. Any bit shifted beyond that field sets ovf; ovf forces mag to all-ones.
- S3 finish:
  - optional rounding applied to the magnitude;
  - max_pos = 2^(OUT_W-1)-1, max_neg magnitude = 2^(OUT_W-1).
  - positive: mag>max_pos or ovf gives out_data=max_pos, out_sat=1.
  - negative: mag>2^(OUT_W-1) or ovf gives out_data=-2^(OUT_W-1), out_sat=1. mag==2^(OUT_W-1) exactly is representable: out_sat=0.
  - otherwise out_data = sign ? -mag : mag.
- Special cases:
  - zero/denormal: out_data=0 regardless of sign, out_sat=0.
  - inf: saturates per sign, out_sat=1.
  - NaN: out_data=0, out_nan=1, out_sat=0.
- Default rounding truncates toward zero. Discarded bits never set out_sat.
- Simultaneous in transfer and out transfer in the same cycle is supported; full throughput is one word per clk.

Optional Feature:
- Macro FLOAT_TO_FIXED_ROUND_EN.
- Defined: S3 rounds to nearest, ties away from zero, i.e. mag += guard. The increment can cause saturation, e.g. 32767.5 gives 32767 with out_sat=1 for OUT_W=16.
- Undefined: truncation toward zero; guard/sticky logic is not built.

Decomposition:
- Shared package float_pkg:
  - constants FP_EXP_W=8, FP_MANT_W=23, FP_EXP_BIAS=127;
  - class enum {FP_ZERO, FP_NORM, FP_INF, FP_NAN};
  - field-extract functions.
- One sub-module, float_unpack: the S1 combinational classify/unpack, reused by later float-domain blocks. Stages S2/S3 stay in float_to_fixed.

Test Plan:
- OUT_W=16, FRAC_W=0:
  - 0x3F800000 (1.0) -> 1.
  - 0xC0700000 (-3.75) -> -3; -4 with FLOAT_TO_FIXED_ROUND_EN.
  - Each result appears exactly 3 cycles after acceptance.
- OUT_W=16, saturation and specials:
  - 0x471C4000 (40000.0) -> 32767, sat=1.
  - 0xC7000000 (-32768.0) -> -32768, sat=0.
  - 0xFF800000 (-Inf) -> -32768, sat=1.
- Specials and small values: 0x7FC00000 (NaN) -> 0, nan=1; 0x80000000 (-0) -> 0; 0x00000001 (denormal) -> 0; 0x3E800000 (0.25) -> 0.
- OUT_W=12, FRAC_W=8:
  - 0x3F000000 (0.5) -> 128.
  - 0x40F00000 (7.5) -> 1920.
  - 0x41000000 (8.0) -> 2047, sat=1.
- Backpressure:
  - Stream 8 back-to-back words while toggling out_ready with pattern 1,0,0,1,1,0...
  - Required: results in order, none lost or duplicated; out_data held stable while out_valid & !out_ready; in_ready low only when stalled.
- Assert reset with 3 words in flight: out_valid=0 the next cycle, no stale word ever emitted; the new stream converts correctly.
